// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and address-width derivation for the scoreboarded register file.
package reg_file_sb_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NREGS_DEF = 16;

    // Smallest w with 2**w >= nregs; NREGS is a power of two so this is exact.
    function automatic int addr_width(input int nregs);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < nregs) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/reg_sb_scoreboard.sv
// Pending-bit scoreboard: tracks reserved destinations, reports hazards and keeps a live count.
module reg_sb_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    localparam int AW = addr_width(NREGS)
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsv_addr,
    output logic          stall,
    output logic          rsv_ack,
    output logic [AW:0]   pend_cnt
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;
    logic             live_rs;
    logic             live_rt;
    logic             live_rsv;
    logic             cnt_dec;

    // Reserve handshake: rsv_en is a one-cycle request, rsv_ack answers in the
    // same cycle; an unacknowledged request has no effect and is not retained.
    // A same-cycle write retires a pending bit before it can cause a hazard.
    always_comb begin
        live_rs  = pending[rs_addr]  && !(wr_en && (wr_addr == rs_addr));
        live_rt  = pending[rt_addr]  && !(wr_en && (wr_addr == rt_addr));
        live_rsv = pending[rsv_addr] && !(wr_en && (wr_addr == rsv_addr));
        stall    = live_rs || live_rt || (rsv_en && live_rsv);
        rsv_ack  = clear_n && rsv_en && !live_rsv;
        cnt_dec  = wr_en && pending[wr_addr];
    end

    // Write clears first, then an accepted reservation sets, so a same-address
    // write-plus-reserve leaves the bit pending.
    always_comb begin
        pending_nxt = pending;
        if (wr_en)   pending_nxt[wr_addr]  = 1'b0;
        if (rsv_ack) pending_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending <= pending_nxt;
            if (rsv_ack && !cnt_dec && (pend_cnt != (AW+1)'(NREGS)))
                pend_cnt <= pend_cnt + (AW+1)'(1);
            else if (cnt_dec && !rsv_ack && (pend_cnt != '0))
                pend_cnt <= pend_cnt - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read one-write register file with write bypass, base-address zeroing and a pending scoreboard.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF,
    localparam int AW = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rs_addr,
    input  logic [AW-1:0]    rt_addr,
    input  logic             ba_out,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic [WIDTH-1:0] rs_data,
    output logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic             rsv_ack,
    output logic [AW:0]      pend_cnt
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Reads are forced to zero while in reset so a live write cannot bypass through.
    always_comb begin
        if (!clear_n || (ba_out && (rs_addr == '0)))
            rs_data = '0;
        else if (wr_en && (wr_addr == rs_addr))
            rs_data = wr_data;
        else
            rs_data = regs[rs_addr];

        if (!clear_n)
            rt_data = '0;
        else if (wr_en && (wr_addr == rt_addr))
            rt_data = wr_data;
        else
            rt_data = regs[rt_addr];
    end

    reg_sb_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .clear_n  (clear_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .stall    (stall),
        .rsv_ack  (rsv_ack),
        .pend_cnt (pend_cnt)
    );

endmodule
